// File: rtl/dispatch_pkg.sv
// Shared widths, FSM state encoding and descriptor layout for the wavefront dispatch scheduler.
package dispatch_pkg;

  localparam int TAG_W   = 15;
  localparam int VGPR_W  = 10;
  localparam int SGPR_W  = 9;
  localparam int LDS_W   = 16;
  localparam int PC_W    = 32;
  localparam int WFSZ_W  = 6;
  localparam int WFCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    ISSUE = 2'd2
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [WFCNT_W-1:0] wf_cnt;
    logic [WFSZ_W-1:0]  wf_size;
    logic [VGPR_W-1:0]  vgpr_base;
    logic [SGPR_W-1:0]  sgpr_base;
    logic [LDS_W-1:0]   lds_base;
    logic [PC_W-1:0]    start_pc;
  } wf_desc_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N     = 1,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wf_dispatch_sched.sv
// Wavefront dispatch scheduler: holds one host descriptor, picks a CU round-robin, issues it.
// Optional DISPATCH_STALL_CNT_EN adds a saturating count of cycles stalled with no free CU.
module wf_dispatch_sched
  import dispatch_pkg::*;
#(
  parameter int NUMOFCU       = 1,
  parameter int MAX_WF_PER_CU = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_wf_valid,
  output logic                     host_wf_ready,
  input  logic [TAG_W-1:0]         host_wf_tag,
  input  logic [WFCNT_W-1:0]       host_wf_cnt,
  input  logic [WFSZ_W-1:0]        host_wf_size,
  input  logic [VGPR_W-1:0]        host_vgpr_base,
  input  logic [SGPR_W-1:0]        host_sgpr_base,
  input  logic [LDS_W-1:0]         host_lds_base,
  input  logic [PC_W-1:0]          host_start_pc,
  output logic [NUMOFCU-1:0]       dispatch2cu_wf_dispatch,
  output logic [WFCNT_W-1:0]       dispatch2cu_wg_wf_count,
  output logic [WFSZ_W-1:0]        dispatch2cu_wf_size_dispatch,
  output logic [SGPR_W-1:0]        dispatch2cu_sgpr_base_dispatch,
  output logic [VGPR_W-1:0]        dispatch2cu_vgpr_base_dispatch,
  output logic [TAG_W-1:0]         dispatch2cu_wf_tag_dispatch,
  output logic [LDS_W-1:0]         dispatch2cu_lds_base_dispatch,
  output logic [PC_W-1:0]          dispatch2cu_start_pc_dispatch,
  input  logic [NUMOFCU-1:0]       cu2dispatch_wf_done,
  input  logic [NUMOFCU*TAG_W-1:0] cu2dispatch_wf_tag_done,
  output logic                     sched_idle,
  output logic [15:0]              done_total,
  output logic                     err_underflow,
  output logic [31:0]              stall_cycles
);

  localparam int PTR_W = (NUMOFCU > 1) ? $clog2(NUMOFCU) : 1;

  state_t               state_reg, state_next;
  wf_desc_t             hold_reg, payload_reg;
  logic [NUMOFCU-1:0]   dispatch_reg, sel_reg;
  logic [NUMOFCU-1:0]   eligible, grant, cnt_zero, underflow;
  logic [PTR_W-1:0]     ptr_reg, grant_idx, ptr_next;
  logic [15:0]          done_total_reg, done_pop;
  logic                 err_reg, grant_en, any_eligible;
  logic                 unused_tag_done;

  // Completion tags are not needed for bookkeeping; only the pulses matter.
  assign unused_tag_done = ^cu2dispatch_wf_tag_done;

  assign grant_en     = (state_reg == ARB);
  assign any_eligible = |eligible;

  rr_arbiter #(
    .N     (NUMOFCU),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (eligible),
    .en    (grant_en),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  for (genvar gi = 0; gi < NUMOFCU; gi++) begin : g_cu
    logic [WFCNT_W-1:0] cnt_reg;
    logic               inc, dec;

    assign inc            = (state_reg == ISSUE) && sel_reg[gi];
    assign dec            = cu2dispatch_wf_done[gi];
    assign eligible[gi]   = (cnt_reg < WFCNT_W'(MAX_WF_PER_CU));
    assign cnt_zero[gi]   = (cnt_reg == '0);
    assign underflow[gi]  = dec && !inc && (cnt_reg == '0);

    // A simultaneous dispatch and completion cancel out.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (inc && !dec) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else if (dec && !inc && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUMOFCU; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
  end

  assign ptr_next = (grant_idx == PTR_W'(NUMOFCU - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    done_pop = '0;
    for (int i = 0; i < NUMOFCU; i++) begin
      done_pop = done_pop + 16'(cu2dispatch_wf_done[i]);
    end
  end

  always_comb begin
    state_next    = state_reg;
    host_wf_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        host_wf_ready = 1'b1;
        if (host_wf_valid) state_next = ARB;
      end
      ARB: begin
        if (any_eligible) state_next = ISSUE;
      end
      ISSUE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      hold_reg       <= '0;
      payload_reg    <= '0;
      dispatch_reg   <= '0;
      sel_reg        <= '0;
      ptr_reg        <= '0;
      done_total_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      done_total_reg <= done_total_reg + done_pop;
      err_reg        <= err_reg | (|underflow);
      dispatch_reg   <= '0;
      if (state_reg == IDLE && host_wf_valid) begin
        hold_reg <= '{tag: host_wf_tag, wf_cnt: host_wf_cnt, wf_size: host_wf_size,
                      vgpr_base: host_vgpr_base, sgpr_base: host_sgpr_base,
                      lds_base: host_lds_base, start_pc: host_start_pc};
      end
      if (grant_en && any_eligible) begin
        sel_reg <= grant;
        ptr_reg <= ptr_next;
      end
      if (state_reg == ISSUE) begin
        dispatch_reg <= sel_reg;
        payload_reg  <= hold_reg;
      end
    end
  end

`ifdef DISPATCH_STALL_CNT_EN
  logic [31:0] stall_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_reg <= '0;
    end else if (grant_en && !any_eligible && (stall_reg != 32'hFFFF_FFFF)) begin
      stall_reg <= stall_reg + 1'b1;
    end
  end

  assign stall_cycles = stall_reg;
`else
  assign stall_cycles = '0;
`endif

  assign sched_idle                     = (state_reg == IDLE) && (&cnt_zero);
  assign done_total                     = done_total_reg;
  assign err_underflow                  = err_reg;
  assign dispatch2cu_wf_dispatch        = dispatch_reg;
  assign dispatch2cu_wg_wf_count        = payload_reg.wf_cnt;
  assign dispatch2cu_wf_size_dispatch   = payload_reg.wf_size;
  assign dispatch2cu_sgpr_base_dispatch = payload_reg.sgpr_base;
  assign dispatch2cu_vgpr_base_dispatch = payload_reg.vgpr_base;
  assign dispatch2cu_wf_tag_dispatch    = payload_reg.tag;
  assign dispatch2cu_lds_base_dispatch  = payload_reg.lds_base;
  assign dispatch2cu_start_pc_dispatch  = payload_reg.start_pc;

endmodule
